// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port round-robin arbiter in front of one single-port
// synchronous SRAM with a registered read port.
//
// Ports A and B each present read/write requests with a req/gnt handshake.
// The grant is combinational, and the granted port drives the SRAM in the
// same cycle. Read data is broadcast on both rdata buses. The owner's rvalid
// identifies which port the data belongs to.
//
// Optional build macro: SRAM_ARB_OREG_EN
//   defined   : read data passes through an extra output register.
//               The read latency is 2 cycles and rdata holds between returns.
//   undefined : rdata is sram_dout directly, with a read latency of 1 cycle.
module sram_arbiter #(
  parameter int AW = 10,
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          rst,
  // port A
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  // port B
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  // SRAM
  output logic          sram_ce,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_din,
  input  logic [DW-1:0] sram_dout
);

  // Round-robin pointer: names the port that wins when both request.
  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

  prio_e prio_q, prio_d;

  // Read-return tracking: the owner is 1 for port B and 0 for port A.
  logic rd_vld_q, rd_vld_d;
  logic rd_own_q, rd_own_d;

  // Return-cycle view of the read pipeline, selected by the build option.
  logic          ret_vld;
  logic          ret_own;
  logic [DW-1:0] ret_data;

  // Arbitration and pointer update; nothing is granted while in reset.
  always_comb begin
    a_gnt  = 1'b0;
    b_gnt  = 1'b0;
    prio_d = prio_q;
    if (!rst) begin
      if (a_req && (!b_req || prio_q == PRIO_A)) begin
        a_gnt = 1'b1;
      end else if (b_req) begin
        b_gnt = 1'b1;
      end
      if (a_gnt) begin
        prio_d = PRIO_B;
      end else if (b_gnt) begin
        prio_d = PRIO_A;
      end
    end
  end

  // Pointer register; reset gives port A first pick.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= PRIO_A;
    end else begin
      prio_q <= prio_d;
    end
  end

  // SRAM drive is muxed from the granted port; all lines are quiet when idle.
  always_comb begin
    sram_ce   = 1'b0;
    sram_we   = 1'b0;
    sram_addr = '0;
    sram_din  = '0;
    if (a_gnt) begin
      sram_ce   = 1'b1;
      sram_we   = a_we;
      sram_addr = a_addr;
      sram_din  = a_wdata;
    end else if (b_gnt) begin
      sram_ce   = 1'b1;
      sram_we   = b_we;
      sram_addr = b_addr;
      sram_din  = b_wdata;
    end
  end

  // A granted read records its owner so the data can be tagged on return.
  always_comb begin
    rd_vld_d = (a_gnt && !a_we) || (b_gnt && !b_we);
    rd_own_d = b_gnt;
  end

  // First owner stage, aligned with sram_dout; reset drops in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q <= 1'b0;
      rd_own_q <= 1'b0;
    end else begin
      rd_vld_q <= rd_vld_d;
      rd_own_q <= rd_own_d;
    end
  end

`ifdef SRAM_ARB_OREG_EN
  logic          ret_vld_q, ret_vld_d;
  logic          ret_own_q, ret_own_d;
  logic [DW-1:0] rdata_q, rdata_d;

  // Second stage: capture the returning data and hold it until the next return.
  always_comb begin
    ret_vld_d = rd_vld_q;
    ret_own_d = rd_own_q;
    rdata_d   = rdata_q;
    if (rd_vld_q) begin
      rdata_d = sram_dout;
    end
  end

  // Output register stage; reset clears the owner pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      ret_vld_q <= 1'b0;
      ret_own_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      ret_vld_q <= ret_vld_d;
      ret_own_q <= ret_own_d;
      rdata_q   <= rdata_d;
    end
  end

  assign ret_vld  = ret_vld_q;
  assign ret_own  = ret_own_q;
  assign ret_data = rdata_q;
`else
  assign ret_vld  = rd_vld_q;
  assign ret_own  = rd_own_q;
  assign ret_data = sram_dout;
`endif

  // Return strobes go only to the owner and are suppressed in a reset cycle.
  always_comb begin
    a_rvalid = ret_vld && !ret_own && !rst;
    b_rvalid = ret_vld &&  ret_own && !rst;
    a_rdata  = ret_data;
    b_rdata  = ret_data;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed, table-driven bench for sram_arbiter with a behavioural SRAM model.
// Build with +define+SRAM_ARB_OREG_EN to exercise the output-register variant.
module tb_sram_arbiter;

  localparam int AW = 10;
  localparam int DW = 128;
`ifdef SRAM_ARB_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [1:0] IDL = 2'd0, RD = 2'd1, WR = 2'd2;  // port op
  localparam logic [1:0] GN = 2'd0, GA = 2'd1, GB = 2'd2;   // grant/owner

  typedef struct {
    logic          rst;
    logic [1:0]    aop;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    logic [1:0]    bop;
    logic [AW-1:0] ba;
    logic [DW-1:0] bd;
    logic [1:0]    eg;   // expected grant in this cycle
    logic [1:0]    ret;  // owner of the read issued in this cycle, if any
    logic [DW-1:0] rdv;  // data that read must return
  } vec_t;

  localparam int N = 26;

  logic          clk;
  logic          rst;
  logic          a_req, a_we, a_gnt, a_rvalid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_req, b_we, b_gnt, b_rvalid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;
  logic          sram_ce, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din, sram_dout;

  int checks = 0;
  int errors = 0;

  vec_t          v [N];
  logic          ea_rv [N+LAT];
  logic          eb_rv [N+LAT];
  logic [DW-1:0] e_rd  [N+LAT];

  logic [DW-1:0] mem [1 << AW];

  sram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous SRAM with registered read data.
  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we) mem[sram_addr] <= sram_din;
      else         sram_dout <= mem[sram_addr];
    end
  end

  function automatic vec_t mk(input logic r, input logic [1:0] aop,
                              input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                              input logic [1:0] bop, input logic [AW-1:0] ba,
                              input logic [DW-1:0] bd, input logic [1:0] eg,
                              input logic [1:0] ret, input logic [DW-1:0] rdv);
    vec_t t;
    t.rst = r; t.aop = aop; t.aa = aa; t.ad = ad;
    t.bop = bop; t.ba = ba; t.bd = bd;
    t.eg = eg; t.ret = ret; t.rdv = rdv;
    return t;
  endfunction

  task automatic drive(input logic r, input logic [1:0] aop,
                       input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic [1:0] bop, input logic [AW-1:0] ba,
                       input logic [DW-1:0] bd);
    rst     = r;
    a_req   = (aop != IDL); a_we = (aop == WR); a_addr = aa; a_wdata = ad;
    b_req   = (bop != IDL); b_we = (bop == WR); b_addr = ba; b_wdata = bd;
  endtask

  task automatic chk1(input string name, input int row, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %b want %b", name, row, got, exp);
    end
  endtask

  task automatic chka(input string name, input int row, input logic [AW-1:0] got,
                      input logic [AW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h want %h", name, row, got, exp);
    end
  endtask

  task automatic chkw(input string name, input int row, input logic [DW-1:0] got,
                      input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h want %h", name, row, got, exp);
    end
  endtask

  initial begin
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    logic          killed;
    int            t;

    drive(1'b1, IDL, '0, '0, IDL, '0, '0);

    //         rst   A op  A addr   A data      B op  B addr    B data     grant ret data
    // 1: reset held with both ports requesting
    v[0]  = mk(1'b1, RD, 10'd1,    128'h0,   RD, 10'd2,    128'h0,   GN, GN, 128'h0);
    v[1]  = mk(1'b1, RD, 10'd1,    128'h0,   RD, 10'd2,    128'h0,   GN, GN, 128'h0);
    v[2]  = mk(1'b1, RD, 10'd1,    128'h0,   RD, 10'd2,    128'h0,   GN, GN, 128'h0);
    // 3: contention right after reset, each port holds until granted
    v[3]  = mk(1'b0, WR, 10'd10,   128'hA0,  WR, 10'd20,   128'hB0,  GA, GN, 128'h0);
    v[4]  = mk(1'b0, WR, 10'd11,   128'hA1,  WR, 10'd20,   128'hB0,  GB, GN, 128'h0);
    v[5]  = mk(1'b0, WR, 10'd11,   128'hA1,  WR, 10'd21,   128'hB1,  GA, GN, 128'h0);
    v[6]  = mk(1'b0, WR, 10'd12,   128'hA2,  WR, 10'd21,   128'hB1,  GB, GN, 128'h0);
    v[7]  = mk(1'b0, RD, 10'd10,   128'h0,   WR, 10'd22,   128'hB2,  GA, GA, 128'hA0);
    v[8]  = mk(1'b0, RD, 10'd11,   128'h0,   WR, 10'd22,   128'hB2,  GB, GN, 128'h0);
    v[9]  = mk(1'b0, RD, 10'd11,   128'h0,   IDL, 10'd0,   128'h0,   GA, GA, 128'hA1);
    // 2: write then read back on consecutive cycles
    v[10] = mk(1'b0, WR, 10'd3,    128'h5A,  IDL, 10'd0,   128'h0,   GA, GN, 128'h0);
    v[11] = mk(1'b0, RD, 10'd3,    128'h0,   IDL, 10'd0,   128'h0,   GA, GA, 128'h5A);
    v[12] = mk(1'b0, IDL, 10'd0,   128'h0,   IDL, 10'd0,   128'h0,   GN, GN, 128'h0);
    v[13] = mk(1'b0, IDL, 10'd0,   128'h0,   IDL, 10'd0,   128'h0,   GN, GN, 128'h0);
    // 4: load mem[1]/mem[2], then pipelined reads A then B
    v[14] = mk(1'b0, WR, 10'd1,    128'h11,  WR, 10'd2,    128'h22,  GB, GN, 128'h0);
    v[15] = mk(1'b0, WR, 10'd1,    128'h11,  IDL, 10'd0,   128'h0,   GA, GN, 128'h0);
    v[16] = mk(1'b0, RD, 10'd1,    128'h0,   IDL, 10'd0,   128'h0,   GA, GA, 128'h11);
    v[17] = mk(1'b0, IDL, 10'd0,   128'h0,   RD, 10'd2,    128'h0,   GB, GB, 128'h22);
    v[18] = mk(1'b0, IDL, 10'd0,   128'h0,   IDL, 10'd0,   128'h0,   GN, GN, 128'h0);
    v[19] = mk(1'b0, IDL, 10'd0,   128'h0,   IDL, 10'd0,   128'h0,   GN, GN, 128'h0);
    // 6: B alone at the top address, granted every cycle
    v[20] = mk(1'b0, IDL, 10'd0,   128'h0,   WR, 10'd1023, 128'hFF,  GB, GN, 128'h0);
    v[21] = mk(1'b0, IDL, 10'd0,   128'h0,   WR, 10'd1022, 128'hEE,  GB, GN, 128'h0);
    v[22] = mk(1'b0, IDL, 10'd0,   128'h0,   RD, 10'd1023, 128'h0,   GB, GB, 128'hFF);
    v[23] = mk(1'b0, RD, 10'd1023, 128'h0,   IDL, 10'd0,   128'h0,   GA, GA, 128'hFF);
    v[24] = mk(1'b0, IDL, 10'd0,   128'h0,   IDL, 10'd0,   128'h0,   GN, GN, 128'h0);
    v[25] = mk(1'b0, IDL, 10'd0,   128'h0,   IDL, 10'd0,   128'h0,   GN, GN, 128'h0);

    // Place each read's expected return LAT rows later, unless reset intervenes.
    for (int i = 0; i < N + LAT; i++) begin
      ea_rv[i] = 1'b0; eb_rv[i] = 1'b0; e_rd[i] = '0;
    end
    for (int i = 0; i < N; i++) begin
      if (v[i].ret != GN) begin
        t = i + LAT;
        killed = 1'b0;
        for (int j = i; j <= t && j < N; j++) if (v[j].rst) killed = 1'b1;
        if (!killed) begin
          ea_rv[t] = (v[i].ret == GA);
          eb_rv[t] = (v[i].ret == GB);
          e_rd[t]  = v[i].rdv;
        end
      end
    end

    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      drive(v[i].rst, v[i].aop, v[i].aa, v[i].ad, v[i].bop, v[i].ba, v[i].bd);
      e_we = 1'b0; e_addr = '0; e_din = '0;
      if (v[i].eg == GA) begin
        e_we = (v[i].aop == WR); e_addr = v[i].aa; e_din = v[i].ad;
      end else if (v[i].eg == GB) begin
        e_we = (v[i].bop == WR); e_addr = v[i].ba; e_din = v[i].bd;
      end
      @(negedge clk);
      chk1("a_gnt", i, a_gnt, v[i].eg == GA);
      chk1("b_gnt", i, b_gnt, v[i].eg == GB);
      chk1("sram_ce", i, sram_ce, v[i].eg != GN);
      chk1("sram_we", i, sram_we, e_we);
      chka("sram_addr", i, sram_addr, e_addr);
      chkw("sram_din", i, sram_din, e_din);
      chk1("a_rvalid", i, a_rvalid, ea_rv[i]);
      chk1("b_rvalid", i, b_rvalid, eb_rv[i]);
      if (ea_rv[i]) chkw("a_rdata", i, a_rdata, e_rd[i]);
      if (eb_rv[i]) chkw("b_rdata", i, b_rdata, e_rd[i]);
      $display("row %0d rst=%b a_gnt=%b b_gnt=%b a_rvalid=%b b_rvalid=%b",
               i, rst, a_gnt, b_gnt, a_rvalid, b_rvalid);
      @(posedge clk); #1;
    end

    // 5: reset in the return cycle of a read suppresses its rvalid.
    drive(1'b0, RD, 10'd3, '0, IDL, '0, '0);
    @(negedge clk);
    chk1("t5 a_gnt", 100, a_gnt, 1'b1);
    $display("t5 A read addr 3 issued a_gnt=%b", a_gnt);
    @(posedge clk); #1;
    for (int k = 1; k < LAT; k++) begin
      drive(1'b0, IDL, '0, '0, IDL, '0, '0);
      @(negedge clk);
      chk1("t5 inflight a_rvalid", 100 + k, a_rvalid, 1'b0);
      @(posedge clk); #1;
    end
    drive(1'b1, IDL, '0, '0, IDL, '0, '0);
    @(negedge clk);
    chk1("t5 rst a_rvalid", 110, a_rvalid, 1'b0);
    chk1("t5 rst b_rvalid", 110, b_rvalid, 1'b0);
    chk1("t5 rst sram_ce", 110, sram_ce, 1'b0);
    $display("t5 rst in return cycle a_rvalid=%b", a_rvalid);
    @(posedge clk); #1;
    drive(1'b0, IDL, '0, '0, RD, 10'd2, '0);
    @(negedge clk);
    chk1("t5 post-rst b_gnt", 111, b_gnt, 1'b1);
    chk1("t5 post-rst a_gnt", 111, a_gnt, 1'b0);
    $display("t5 B alone after rst b_gnt=%b", b_gnt);
    @(posedge clk); #1;
    for (int k = 1; k <= LAT; k++) begin
      drive(1'b0, IDL, '0, '0, IDL, '0, '0);
      @(negedge clk);
      chk1("t5 stale a_rvalid", 111 + k, a_rvalid, 1'b0);
      chk1("t5 b_rvalid", 111 + k, b_rvalid, k == LAT);
      if (k == LAT) chkw("t5 b_rdata", 111 + k, b_rdata, 128'h22);
      @(posedge clk); #1;
    end
    // After B's grant the pointer is back at A, so A wins the next contention.
    drive(1'b0, WR, 10'd5, 128'h55, WR, 10'd6, 128'h66);
    @(negedge clk);
    chk1("t5 contend a_gnt", 120, a_gnt, 1'b1);
    chk1("t5 contend b_gnt", 120, b_gnt, 1'b0);
    $display("t5 contention after B grant a_gnt=%b b_gnt=%b", a_gnt, b_gnt);
    @(posedge clk); #1;
    drive(1'b0, IDL, '0, '0, IDL, '0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
